// File: rtl/disp_scan_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : disp_scan_if
// Description : Bundle of load/data and display-side signals for the
//               multiplexed digit scanner.
//   load        one-cycle strobe, capture din
//   din         packed BCD value, nibble 0 is the least-significant digit
//   a3..a0      code of the digit in the current slot (a3 = MSB)
//   dig_en      one-hot active-high digit enable
//   pending     a loaded value waits for the frame boundary
//   frame_done  one-cycle pulse when the scan wraps to digit 0
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_scan_if #(
    parameter int DIGITS = 4
) ();
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic                  a3;
    logic                  a2;
    logic                  a1;
    logic                  a0;
    logic [DIGITS-1:0]     dig_en;
    logic                  pending;
    logic                  frame_done;

    // Host side: issues loads, observes the display lines.
    modport master (
        output load, din,
        input  a3, a2, a1, a0, dig_en, pending, frame_done
    );

    // Scanner side.
    modport slave (
        input  load, din,
        output a3, a2, a1, a0, dig_en, pending, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/disp_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : disp_scan_driver
// Description : Time-multiplexed digit scanner. Holds a multi-digit BCD value
//               and presents one digit per slot on a3..a0 together with a
//               one-hot digit enable. New values are double-buffered and only
//               take effect at a frame boundary.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - disp_scan_if.slave (load/din in; a3..a0, dig_en,
//                        pending, frame_done out)
// Parameters  : DIGITS   (2..8)   digits scanned; must match bus DIGITS
//               TICK_DIV (>=2)    clock cycles per digit slot
//               GUARD    (<TICK_DIV) dark cycles at the start of each slot
//               BLANK_LZ (0/1)    blank leading zeros
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000,
    parameter int GUARD    = 2,
    parameter int BLANK_LZ = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    disp_scan_if.slave       bus
);
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int SLOT_W = $clog2(DIGITS);
    localparam int VAL_W  = 4 * DIGITS;

    localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(DIGITS - 1);

    // State registers
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [SLOT_W-1:0] slot_q,       slot_d;
    logic [VAL_W-1:0]  act_q,        act_d;
    logic [VAL_W-1:0]  shd_q,        shd_d;
    logic              pending_q,    pending_d;
    logic              frame_done_q, frame_done_d;
    logic [3:0]        code_q,       code_d;
    logic [DIGITS-1:0] dig_en_q,     dig_en_d;

    // Combinational helpers
    logic              w_wrap;
    logic              w_boundary;
    logic              w_in_guard;
    logic              w_higher_zero;
    logic [DIGITS-1:0] w_blank;
    logic [3:0]        w_sel_nib;
    logic              w_sel_blank;

    always_comb begin
        w_wrap        = (cnt_q == C_CNT_LAST);
        w_boundary    = w_wrap && (slot_q == C_SLOT_LAST);

        // Tick counter and slot index
        cnt_d  = w_wrap ? '0 : cnt_q + CNT_W'(1);
        slot_d = slot_q;
        if (w_wrap) begin
            slot_d = w_boundary ? '0 : slot_q + SLOT_W'(1);
        end

        // Double buffer. A load coinciding with the boundary bypasses the
        // shadow and lands in the active value, superseding any pending one.
        act_d     = act_q;
        shd_d     = shd_q;
        pending_d = pending_q;
        if (w_boundary) begin
            if (bus.load) begin
                act_d = bus.din;
            end else if (pending_q) begin
                act_d = shd_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            shd_d     = bus.din;
            pending_d = 1'b1;
        end

        frame_done_d = w_boundary;

        // Leading-zero blanking from the top digit down, on the value that
        // will be active after this edge so a boundary swap is seen at once.
        w_higher_zero = 1'b1;
        w_blank       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_higher_zero = w_higher_zero && (act_d[4*i +: 4] == 4'h0);
            w_blank[i]    = (BLANK_LZ != 0) && (i != 0) && w_higher_zero;
        end

        // Select the nibble and blank flag of the next slot.
        w_sel_nib   = 4'h0;
        w_sel_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot_d == SLOT_W'(i)) begin
                w_sel_nib   = act_d[4*i +: 4];
                w_sel_blank = w_blank[i];
            end
        end

        w_in_guard = (int'(cnt_d) < GUARD);

        code_d   = w_sel_blank ? 4'h0 : w_sel_nib;
        dig_en_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_en_d[i] = (slot_d == SLOT_W'(i)) && !w_sel_blank && !w_in_guard;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            slot_q       <= '0;
            act_q        <= '0;
            shd_q        <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            code_q       <= 4'h0;
            dig_en_q     <= '0;
        end else begin
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            act_q        <= act_d;
            shd_q        <= shd_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            code_q       <= code_d;
            dig_en_q     <= dig_en_d;
        end
    end

    assign bus.a3         = code_q[3];
    assign bus.a2         = code_q[2];
    assign bus.a1         = code_q[1];
    assign bus.a0         = code_q[0];
    assign bus.dig_en     = dig_en_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
